uart_send: RTL
==============

Name: uart_send

Overview:
- UART transmitter: serialises one 8-bit byte per request onto uart_txd.
- Frame: start bit (0), 8 data bits LSB first, optional parity bit, 1 or 2 stop bits (1).
- Pairs with the team's UART receiver on the same sys_clk domain; line idles high.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 9600, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer divide), clocks per bit; legal range 2..65536
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
uart_en  in  1  transmit request, sampled as a level
uart_din  in  8  byte to send, sampled with uart_en
uart_tx_busy  out  1  high while a frame is in progress
uart_tx_done  out  1  one-cycle pulse at frame end
uart_txd  out  1  serial output, registered

Behaviour:
- Reset, asynchronous: uart_txd=1, uart_tx_busy=0, uart_tx_done=0, FSM=IDLE, counters=0, shift register=0.
- Accept rule: a request is accepted in cycle N when uart_en=1 && uart_tx_busy=0.
  - uart_din is latched into the shift register in cycle N.
  - Parity is computed from the latched byte: odd → bit = ~^din; even → bit = ^din.
  - From N+1, uart_tx_busy=1 and uart_txd=0.
- Requests while busy are ignored, not queued. uart_din changes while busy have no effect.
- FSM states: IDLE → START → DATA → PARITY (only if PARITY≠0) → STOP → IDLE.
- Bit timing:
  - clk_cnt (16 bit) counts 0..BPS_CNT-1 in every non-IDLE state.
  - Each bit is held for exactly BPS_CNT clocks.
  - State or bit advances when clk_cnt==BPS_CNT-1; clk_cnt then wraps to 0.
- DATA state:
  - bit_cnt (3 bit) selects bit 0..7; uart_txd = data[bit_cnt].
  - Leaves DATA when bit_cnt==7 and clk_cnt==BPS_CNT-1.
- PARITY state: uart_txd = parity bit for one bit time.
- STOP state:
  - uart_txd=1 for STOP_BITS×BPS_CNT clocks, counted with stop_cnt.
  - In the final cycle of the last stop bit: uart_tx_done=1 for exactly that cycle, and the FSM returns to IDLE.
  - uart_tx_busy drops to 0 on the following cycle.
- Back-to-back: with uart_en held high, the next request is accepted in the first cycle busy=0. The new start bit then begins one cycle after that. Line gap between frames = 1 clock of idle high.
- Frame length = BPS_CNT×(10 + (PARITY≠0) + (STOP_BITS-1)) clocks of busy=1.
- uart_txd changes only on bit boundaries and is glitch-free (registered output).
- Reset mid-frame: line returns high immediately, busy=0, and no done pulse is generated. The partial frame is abandoned.
- Illegal parameter values (PARITY>2, STOP_BITS∉{1,2}) are trapped by a simulation-only $error in an initial block.

Test Plan:
- Reset and idle, CLK_FREQ=1000000, UART_BPS=100000 (BPS_CNT=10):
  - Assert sys_rst_n low asynchronously → txd=1, busy=0, done=0.
  - Release with uart_en=0 for 100 clocks → outputs unchanged.
- Single byte, 8N1, din=0x55, uart_en pulsed 1 cycle:
  - txd = 0 for 10 clocks, then 1,0,1,0,1,0,1,0 at 10 clocks each, then 1 for 10 clocks.
  - busy high exactly 100 clocks; done pulses once in the last stop-bit clock.
- Parity frames:
  - PARITY=2, din=0xA7 (five ones) → parity bit 1, busy = 110 clocks.
  - PARITY=1, same byte → parity bit 0.
  - PARITY=1, din=0x00 → parity bit 1.
- Two stop bits and back-to-back: STOP_BITS=2, uart_en held high with din=0x01 then 0x80.
  - Each frame is 110 clocks; stop high for 20 clocks.
  - Exactly 1 idle clock between frames; second frame carries 0x80.
- Ignore while busy: second uart_en pulse with din=0xFF at clock 30 of a 0x3C frame, and din toggled mid-frame.
  - Transmitted byte is 0x3C; no second frame; one done pulse.
- Reset mid-frame: sys_rst_n low during DATA bit 3 of din=0x00.
  - txd=1 and busy=0 asynchronously; no done pulse.
  - After release, a new request for 0xC3 transmits correctly.

Source files
------------

// File: rtl/uart_send.sv
// uart_send: UART transmitter.
// Sends one byte per accepted request as start bit, 8 data bits (LSB first),
// an optional odd/even parity bit and 1 or 2 stop bits. The line idles high.
// All outputs are registered, so uart_txd only moves on bit boundaries.
`timescale 1ns/1ps
module uart_send #(
   parameter int CLK_FREQ  = 50000000,
   parameter int UART_BPS  = 9600,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       uart_en,
   input  logic [7:0] uart_din,
   output logic       uart_tx_busy,
   output logic       uart_tx_done,
   output logic       uart_txd
);

   localparam int          BPS_CNT   = CLK_FREQ / UART_BPS;
   localparam logic [15:0] BPS_LAST  = 16'(BPS_CNT - 1);
   // One clock before the end of a bit; lets the done pulse be registered
   // and still line up with the final stop-bit clock.
   localparam logic [15:0] BPS_PRE   = 16'(BPS_CNT - 2);
   localparam logic        STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_PAR   = 3'd3,
      S_STOP  = 3'd4
   } state_t;

   state_t      state;
   state_t      next_state;

   logic [15:0] clk_cnt;
   logic [15:0] clk_cnt_nxt;
   logic [2:0]  bit_cnt;
   logic [2:0]  bit_cnt_nxt;
   logic        stop_cnt;
   logic        stop_cnt_nxt;
   logic [7:0]  shift_reg;
   logic        par_bit;

   logic        txd_nxt;
   logic        busy_nxt;
   logic        done_nxt;
   logic        accept;
   logic        bit_end;

   // Parity of the latched byte: odd makes the total count of ones odd.
   function automatic logic par_calc(input logic [7:0] d);
      if (PARITY == 1)
         return ~^d;
      return ^d;
   endfunction

`ifndef SYNTHESIS
   // Trap parameter combinations the frame logic does not support.
   initial begin
      if (PARITY < 0 || PARITY > 2)
         $error("uart_send: PARITY=%0d is not 0, 1 or 2", PARITY);
      if (STOP_BITS != 1 && STOP_BITS != 2)
         $error("uart_send: STOP_BITS=%0d is not 1 or 2", STOP_BITS);
      if (BPS_CNT < 2 || BPS_CNT > 65536)
         $error("uart_send: BPS_CNT=%0d outside 2..65536", BPS_CNT);
   end
`endif

   // Busy is registered from the FSM, so idle and not-busy are the same thing.
   assign accept  = uart_en && !uart_tx_busy;
   assign bit_end = (clk_cnt == BPS_LAST);

   // FSM state register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   // FSM next-state logic: every bit lasts exactly BPS_CNT clocks.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (accept) next_state = S_START;
         S_START: if (bit_end) next_state = S_DATA;
         S_DATA:  if (bit_end && bit_cnt == 3'd7)
                     next_state = (PARITY != 0) ? S_PAR : S_STOP;
         S_PAR:   if (bit_end) next_state = S_STOP;
         S_STOP:  if (bit_end && stop_cnt == STOP_LAST) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // FSM outputs: counter updates and the next registered line level.
   always_comb begin
      clk_cnt_nxt  = 16'd0;
      bit_cnt_nxt  = 3'd0;
      stop_cnt_nxt = 1'b0;
      txd_nxt      = 1'b1;

      if (state != S_IDLE && !bit_end)
         clk_cnt_nxt = clk_cnt + 16'd1;

      // bit_cnt wraps 7 -> 0 as DATA is left, so it is 0 on the next frame.
      if (state == S_DATA)
         bit_cnt_nxt = bit_end ? bit_cnt + 3'd1 : bit_cnt;

      if (state == S_STOP && !(bit_end && stop_cnt == STOP_LAST))
         stop_cnt_nxt = bit_end ? stop_cnt + 1'b1 : stop_cnt;

      // The line level follows the state being entered so that the
      // registered output changes together with the state.
      case (next_state)
         S_START: txd_nxt = 1'b0;
         S_DATA:  txd_nxt = shift_reg[bit_cnt_nxt];
         S_PAR:   txd_nxt = par_bit;
         default: txd_nxt = 1'b1;
      endcase

      busy_nxt = (next_state != S_IDLE);
      done_nxt = (state == S_STOP) && (stop_cnt == STOP_LAST) && (clk_cnt == BPS_PRE);
   end

   // Counters, latched byte/parity and registered outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         clk_cnt      <= 16'd0;
         bit_cnt      <= 3'd0;
         stop_cnt     <= 1'b0;
         shift_reg    <= 8'd0;
         par_bit      <= 1'b0;
         uart_txd     <= 1'b1;
         uart_tx_busy <= 1'b0;
         uart_tx_done <= 1'b0;
      end else begin
         clk_cnt      <= clk_cnt_nxt;
         bit_cnt      <= bit_cnt_nxt;
         stop_cnt     <= stop_cnt_nxt;
         uart_txd     <= txd_nxt;
         uart_tx_busy <= busy_nxt;
         uart_tx_done <= done_nxt;
         if (accept) begin
            shift_reg <= uart_din;
            par_bit   <= par_calc(uart_din);
         end
      end
   end

endmodule
